// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch-side definitions: state encoding and instruction size.
// Kept generic so the data-side requester can reuse the same encoding.
package inst_fetch_unit_pkg;

  localparam int INST_BYTES = 4;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_FETCH = 2'd0;
  localparam fetch_state_t ST_WAIT  = 2'd1;
  localparam fetch_state_t ST_VALID = 2'd2;
  localparam fetch_state_t ST_HALT  = 2'd3;

endpackage

// File: rtl/fetch_timer.sv
// Clearable wait counter; expire flags the cycle whose increment
// brings the count up to TIMEOUT_CYCLES.
module fetch_timer #(
  parameter  int TIMEOUT_CYCLES = 15,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (enable)
      count <= count + CNT_W'(1);
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/inst_fetch_unit.sv
// Single-outstanding instruction fetcher: FETCH -> WAIT -> VALID loop,
// redirect support, sticky error with HALT on timeout or misaligned target.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        inst_accept,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid,
  output logic        fetch_error
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_next;
  logic         misaligned;
  logic         expire;

  assign pc_next    = pc + 32'(INST_BYTES);
  assign misaligned = redirect_pc[1:0] != 2'b00;

  fetch_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == ST_FETCH),
    .enable (state == ST_WAIT),
    .expire (expire)
  );

  // mem_address is only written on transitions into FETCH, so it stays
  // frozen through WAIT/VALID and holds its last value in HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      mem_address <= RESET_PC;
      inst_out    <= '0;
      pc_out      <= RESET_PC;
      inst_valid  <= 1'b0;
      fetch_error <= 1'b0;
    end else if (state != ST_HALT && redirect_valid) begin
      inst_valid <= 1'b0;
      if (misaligned) begin
        fetch_error <= 1'b1;
        state       <= ST_HALT;
      end else begin
        pc          <= redirect_pc;
        mem_address <= redirect_pc;
        state       <= ST_FETCH;
      end
    end else begin
      case (state)
        ST_FETCH: state <= ST_WAIT;
        ST_WAIT: begin
          if (mem_ready) begin
            inst_out   <= mem_read_data;
            pc_out     <= pc;
            inst_valid <= 1'b1;
            state      <= ST_VALID;
          end else if (expire) begin
            fetch_error <= 1'b1;
            state       <= ST_HALT;
          end
        end
        ST_VALID: begin
          if (inst_accept) begin
            inst_valid  <= 1'b0;
            pc          <= pc_next;
            mem_address <= pc_next;
            state       <= ST_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous active-high reset, reset.
REQ-002 The block SHALL have the following parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- TIMEOUT_CYCLES, 15, maximum wait cycles per fetch before an error is raised (at least 2).
REQ-003 The block SHALL have the following ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- mem_address  out  32  byte address to instruction memory, held stable for the whole fetch.
- mem_read_data  in  32  instruction word, valid only while mem_ready=1.
- mem_ready  in  1  memory has data for the current address.
- redirect_valid  in  1  branch/jump redirect request.
- redirect_pc  in  32  redirect target.
- inst_accept  in  1  decode stage consumes inst_out this cycle.
- inst_out  out  32  fetched instruction.
- pc_out  out  32  address of inst_out.
- inst_valid  out  1  inst_out/pc_out hold a valid instruction.
- fetch_error  out  1  sticky error: timeout or misaligned PC.

Function
REQ-004 The block SHALL implement four states: FETCH, WAIT, VALID and HALT.
REQ-005 In FETCH (one cycle), the block SHALL drive mem_address=pc, clear the wait counter and go to WAIT; mem_ready SHALL be ignored in FETCH, because memory ready from the previous address is stale.
REQ-006 In WAIT, the counter SHALL increment each cycle; on mem_ready=1 the block SHALL capture mem_read_data into inst_out and pc into pc_out, and enter VALID next cycle.
REQ-007 In VALID, the block SHALL hold inst_valid=1 with inst_out and pc_out stable until inst_accept=1; then pc<=pc+4 (mod 2^32, wrap allowed) and the state goes to FETCH.
REQ-008 mem_address SHALL change only on entry to FETCH; it SHALL never change while in WAIT.
REQ-009 A fetch latency with memory latency L SHALL be 1 (FETCH) + L (WAIT) cycles, with inst_valid rising the cycle after mem_ready is sampled.
REQ-010 redirect_valid SHALL have priority in FETCH, WAIT and VALID: pc<=redirect_pc, the in-flight fetch is discarded, inst_valid=0 next cycle, and the state goes to FETCH.
REQ-011 Redirect in the same cycle as mem_ready SHALL discard the data.
REQ-012 Redirect in the same cycle as inst_accept SHALL treat the current instruction as consumed, with the redirect target as next pc (not pc+4).
REQ-013 If redirect_pc[1:0]!=0, the block SHALL set fetch_error=1 and enter HALT.
REQ-014 If the wait counter reaches TIMEOUT_CYCLES without mem_ready, the block SHALL set fetch_error=1 and enter HALT.
REQ-015 HALT SHALL be exited only by reset; in HALT, inst_valid=0, mem_address SHALL hold its last value, and redirect SHALL be ignored.
REQ-016 fetch_error SHALL be sticky until reset.

Reset
REQ-017 On reset, the block SHALL set: state=FETCH, pc=RESET_PC, mem_address=RESET_PC, inst_out=0, pc_out=RESET_PC, inst_valid=0, fetch_error=0, wait counter=0.
REQ-018 Reset SHALL override any simultaneous redirect or mem_ready.
REQ-019 Reset mid-WAIT SHALL drop the pending fetch.
REQ-020 The first fetch after reset SHALL start in the cycle after reset deasserts.

Structure
REQ-021 A shared package SHALL hold the state encoding type and the INST_BYTES=4 constant; this package is reusable by the data-side requester.
REQ-022 One sub-module, fetch_timer, SHALL implement the clearable wait counter with a timeout compare (width from $clog2(TIMEOUT_CYCLES+1)).
REQ-023 All other logic SHALL stay in inst_fetch_unit.

Verification
REQ-024 The bench SHALL cover the following directed scenarios, using a memory model with latency 4 and ready cleared on address change:
- Reset, accept tied 1 -> inst_valid every 6 cycles; pc_out sequence 0, 4, 8, 12; inst_out matches memory words 0-3.
- Accept held 0 for 10 cycles in VALID -> inst_out/pc_out stable; mem_address stable; no new fetch; accept then -> next pc_out=pc+4.
- Redirect to 32'h40 during WAIT of pc 8 -> word 8 never appears; next inst_valid has pc_out=32'h40.
- Redirect coincident with mem_ready, and separately with inst_accept -> data discarded; next pc_out=redirect_pc in both cases.
- Memory never asserts ready -> fetch_error=1 after 15 WAIT cycles; HALT; a subsequent redirect ignored; reset clears.
- Redirect to 32'h42 -> fetch_error=1, HALT; start pc 32'hFFFF_FFFC -> next pc_out wraps to 0.
